// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the unified-memory arbiter
package mem_arbiter_pkg;

  localparam int MEM_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arbStateT;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ownerT;

endpackage

// File: rtl/mem_arb_cnt.sv
// rtl/mem_arb_cnt.sv - loadable down-counter that times one memory access
module mem_arb_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data ports onto one multi-cycle memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic          d_dump,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic          mem_dump,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  arbStateT      state, stateNext;
  ownerT         owner, lastGrant, grantOwn;
  logic          grant, cntZero, ownerReq, busy, resp;
  logic          wrQ, dumpQ, errQ;
  logic [AW-1:0] addrQ, selAddr;
  logic [DW-1:0] wdataQ, rdataQ;

  assign busy     = (state == BUSY);
  assign resp     = (state == RESP);
  assign ownerReq = (owner == OWN_D) ? d_req : i_req;

  // Data port wins a tie unless it won the previous grant.
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    grantOwn  = (d_req && (!i_req || (lastGrant != OWN_D))) ? OWN_D : OWN_I;
    selAddr   = (grantOwn == OWN_D) ? d_addr : i_addr;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant     = 1'b1;
          stateNext = selAddr[0] ? RESP : BUSY;
        end
      end
      BUSY:    if (cntZero) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_I;
      lastGrant <= OWN_I;
      addrQ     <= '0;
      wrQ       <= 1'b0;
      wdataQ    <= '0;
      dumpQ     <= 1'b0;
      errQ      <= 1'b0;
      rdataQ    <= '0;
    end else if (grant) begin
      owner     <= grantOwn;
      lastGrant <= grantOwn;
      addrQ     <= selAddr;
      wrQ       <= (grantOwn == OWN_D) & d_wr;
      wdataQ    <= (grantOwn == OWN_D) ? d_wdata : '0;
      dumpQ     <= (grantOwn == OWN_D) & d_dump;
      errQ      <= selAddr[0];
      rdataQ    <= '0;
    end else if (busy) begin
      // A requester abandoning its access mid-flight is flagged, but the access still finishes.
      if (!ownerReq) errQ <= 1'b1;
      if (cntZero)   rdataQ <= wrQ ? '0 : mem_rdata;
    end
  end

  mem_arb_cnt #(.W(CW)) uCnt (
    .clk     (clk),
    .rst     (rst),
    .load    (grant & ~selAddr[0]),
    .loadVal (CW'(MEM_LAT - 1)),
    .dec     (busy),
    .zero    (cntZero)
  );

  assign mem_en    = busy;
  assign mem_wr    = busy & wrQ;
  assign mem_dump  = busy & dumpQ;
  assign mem_addr  = busy ? addrQ : '0;
  assign mem_wdata = busy ? wdataQ : '0;

  assign i_done  = resp & (owner == OWN_I);
  assign d_done  = resp & (owner == OWN_D);
  assign i_rdata = i_done ? rdataQ : '0;
  assign d_rdata = d_done ? rdataQ : '0;
  assign err     = resp & errQ;
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule
